wbc_vicx: RTL and testbench

//  Parametrised vectored interrupt controller: next generation of the fixed 3-source VIC in the terminal
//  top level. Adds N sources, per-source mask, per-source edge/level mode, readable and clearable pending

---
 rtl/wbc_vicx.sv | 102 ++++++++++
 tb/tb_wbc_vicx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wbc_vicx.sv
// wbc_vicx: N-source vectored interrupt controller with mask, edge/level pending, priority and Wishbone regs
module wbc_vicx #(
    parameter int          N         = 3,
    parameter logic [15:0] MASK_INIT = 16'hFFFF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wb_adr_i,
    input  logic [15:0]     wb_dat_i,
    output logic [15:0]     wb_dat_o,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    output logic            wb_ack_o,
    output logic            wb_irq_o,
    output logic [15:0]     vic_dat_o,
    input  logic            vic_stb_i,
    output logic            vic_ack_o,
    input  logic            wb_una_i,
    input  logic [15:0]     rsel,
    input  logic [16*N-1:0] ivec,
    input  logic [N-1:0]    ireq,
    input  logic [N-1:0]    imode,
    output logic [N-1:0]    iack
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t      state_q, state_d;
    logic [N-1:0] mask_q, mask_d, edge_q, edge_d, ireq_q, iack_q, grant;
    logic [N-1:0] pend, req, hot, clr_w;
    logic [15:0]  vec, pend16, mask16, wdat_q, wdat_d, vdat_q, vdat_d;
    logic         irq_q, irq_d, wack_q, wb_go, wr;
    logic         unused_bits;
    assign unused_bits = ^wb_dat_i;
    always_comb begin
        pend   = (imode & edge_q) | (~imode & ireq);
        req    = pend & mask_q;
        vec    = '0;
        hot    = '0;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                vec    = ivec[16*k +: 16];
                hot    = '0;
                hot[k] = 1'b1;
            end
        end
        pend16         = '0;
        pend16[N-1:0]  = pend;
        mask16         = '0;
        mask16[N-1:0]  = mask_q;
    end
    assign wb_go  = wb_cyc_i & wb_stb_i & ~wack_q;
    assign wr     = wb_go & wb_we_i;
    assign clr_w  = (wr & wb_adr_i) ? wb_dat_i[N-1:0] : '0;
    assign mask_d = (wr & ~wb_adr_i) ? wb_dat_i[N-1:0] : mask_q;
    assign wdat_d = (wb_go & ~wb_we_i) ? (wb_adr_i ? pend16 : mask16) : '0;
    assign edge_d = (imode & ireq & ~ireq_q) | (edge_q & ~(grant | clr_w));
    always_comb begin
        state_d = state_q;
        grant   = '0;
        vdat_d  = vdat_q;
        if (state_q == IDLE) begin
            if (vic_stb_i) begin
                state_d = ACK;
                grant   = (wb_una_i || req == '0) ? '0 : hot;
                vdat_d  = (!wb_una_i && req != '0) ? vec : rsel;
            end
        end else if (!vic_stb_i) begin
            state_d = IDLE;
            vdat_d  = '0;
        end
        irq_d = (state_d == IDLE) & (|req);
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            mask_q  <= MASK_INIT[N-1:0];
            edge_q  <= '0;
            ireq_q  <= '0;
            iack_q  <= '0;
            irq_q   <= 1'b0;
            wack_q  <= 1'b0;
            wdat_q  <= '0;
            vdat_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            ireq_q  <= ireq;
            iack_q  <= grant;
            irq_q   <= irq_d;
            wack_q  <= wb_go;
            wdat_q  <= wdat_d;
            vdat_q  <= vdat_d;
        end
    end
    assign wb_dat_o  = wdat_q;
    assign wb_ack_o  = wack_q;
    assign wb_irq_o  = irq_q;
    assign vic_dat_o = vdat_q;
    assign vic_ack_o = (state_q == ACK);
    assign iack      = iack_q;
endmodule

// File: tb/tb_wbc_vicx.sv
// tb_wbc_vicx: table-driven and scoreboard bench for the wbc_vicx interrupt controller
module tb_wbc_vicx;
    localparam int N = 3;
    localparam logic [15:0] VEC [3] = '{16'o054, 16'o060, 16'o064};
    logic            clk = 1'b0, rst;
    logic            wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o, wb_irq_o;
    logic [15:0]     wb_dat_i, wb_dat_o, vic_dat_o, rsel;
    logic            vic_stb_i, vic_ack_o, wb_una_i;
    logic [16*N-1:0] ivec;
    logic [N-1:0]    ireq, imode, iack;
    always #5 clk = ~clk;
    assign ivec = {VEC[2], VEC[1], VEC[0]};
    wbc_vicx #(.N(N), .MASK_INIT(16'hFFFF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .wb_irq_o(wb_irq_o), .vic_dat_o(vic_dat_o), .vic_stb_i(vic_stb_i),
        .vic_ack_o(vic_ack_o), .wb_una_i(wb_una_i), .rsel(rsel), .ivec(ivec),
        .ireq(ireq), .imode(imode), .iack(iack)
    );
    typedef struct packed {logic [15:0] dat; logic [N-1:0] hot;} exp_t;
    typedef struct {logic we; logic adr; logic [15:0] dat; logic [15:0] exp;} reg_vec_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic push(input logic [15:0] d, input logic [N-1:0] h);
        exp_t e;
        e.dat = d;
        e.hot = h;
        sb.push_back(e);
    endtask
    task automatic wb_access(input logic we, input logic adr, input logic [15:0] dat, output logic [15:0] rd);
        int n;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        n = 0;
        do begin @(negedge clk); n++; end while (!wb_ack_o && n < 10);
        chk("wb_ack", {15'b0, wb_ack_o}, 16'd1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask
    task automatic wr(input logic adr, input logic [15:0] dat);
        logic [15:0] d;
        wb_access(1'b1, adr, dat, d);
    endtask
    task automatic rd_chk(input string name, input logic adr, input logic [15:0] exp);
        logic [15:0] d;
        wb_access(1'b0, adr, 16'h0, d);
        chk(name, d, exp);
    endtask
    task automatic pulse(input logic [N-1:0] p);
        @(negedge clk); ireq = p;
        @(negedge clk); ireq = '0;
    endtask
    task automatic fetch(input logic una);
        int n;
        exp_t e;
        @(negedge clk);
        vic_stb_i = 1'b1; wb_una_i = una;
        n = 0;
        do begin @(negedge clk); n++; end while (!vic_ack_o && n < 10);
        chk("vic_ack", {15'b0, vic_ack_o}, 16'd1);
        chk("sb_nonempty", {15'b0, sb.size() != 0}, 16'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("vic_dat", vic_dat_o, e.dat);
        chk("iack", {13'b0, iack}, {13'b0, e.hot});
        @(negedge clk);
        chk("iack_pulse", {13'b0, iack}, 16'd0);
        chk("ack_held", {15'b0, vic_ack_o}, 16'd1);
        vic_stb_i = 1'b0; wb_una_i = 1'b0;
        @(negedge clk);
        chk("ack_drop", {15'b0, vic_ack_o}, 16'd0);
        chk("dat_drop", vic_dat_o, 16'd0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        reg_vec_t rv [7];
        logic [N-1:0] pats [4];
        int n;
        rv[0] = '{1'b1, 1'b0, 16'hFFFA, 16'h0000};
        rv[1] = '{1'b0, 1'b0, 16'h0000, 16'h0002};
        rv[2] = '{1'b1, 1'b0, 16'h0005, 16'h0000};
        rv[3] = '{1'b0, 1'b0, 16'h0000, 16'h0005};
        rv[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000};
        rv[5] = '{1'b1, 1'b0, 16'h0007, 16'h0000};
        rv[6] = '{1'b0, 1'b0, 16'h0000, 16'h0007};
        pats = '{3'b111, 3'b011, 3'b110, 3'b101};
        rst = 1'b1; wb_adr_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_dat_i = '0; vic_stb_i = 1'b0; wb_una_i = 1'b0; rsel = '0; ireq = '0; imode = 3'b111;
        repeat (3) @(negedge clk);
        chk("rst_irq", {15'b0, wb_irq_o}, 16'd0);
        chk("rst_vack", {15'b0, vic_ack_o}, 16'd0);
        chk("rst_vdat", vic_dat_o, 16'd0);
        chk("rst_iack", {13'b0, iack}, 16'd0);
        chk("rst_wack", {15'b0, wb_ack_o}, 16'd0);
        rst = 1'b0;
        rd_chk("rst_mask", 1'b0, 16'h0007);
        rd_chk("rst_pend", 1'b1, 16'h0000);
        foreach (rv[i]) begin
            logic [15:0] d;
            wb_access(rv[i].we, rv[i].adr, rv[i].dat, d);
            if (!rv[i].we) chk("reg_tbl", d, rv[i].exp);
        end
        pulse(3'b001);
        chk("t1_irq_early", {15'b0, wb_irq_o}, 16'd0);
        @(negedge clk);
        chk("t1_irq", {15'b0, wb_irq_o}, 16'd1);
        push(VEC[0], 3'b001);
        fetch(1'b0);
        chk("t1_irq_after", {15'b0, wb_irq_o}, 16'd0);
        foreach (pats[i]) begin
            pulse(pats[i]);
            n = 0;
            for (int k = N - 1; k >= 0; k--)
                if (pats[i][k]) begin push(VEC[k], 3'(1 << k)); n++; end
            repeat (n) fetch(1'b0);
            chk("prio_irq_after", {15'b0, wb_irq_o}, 16'd0);
        end
        wr(1'b0, 16'h0002);
        pulse(3'b101);
        repeat (2) @(negedge clk);
        chk("t3_irq_masked", {15'b0, wb_irq_o}, 16'd0);
        rd_chk("t3_pend", 1'b1, 16'h0005);
        wr(1'b0, 16'h0001);
        @(negedge clk);
        chk("t3_irq_unmask", {15'b0, wb_irq_o}, 16'd1);
        push(VEC[0], 3'b001);
        fetch(1'b0);
        chk("t3_irq_after", {15'b0, wb_irq_o}, 16'd0);
        wr(1'b1, 16'h0004);
        wr(1'b0, 16'h0007);
        rd_chk("t3_pend_clr", 1'b1, 16'h0000);
        pulse(3'b001);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 1'b1; wb_dat_i = 16'h0001;
        ireq = 3'b001;
        @(negedge clk);
        chk("t4_ack", {15'b0, wb_ack_o}, 16'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; ireq = '0;
        @(negedge clk);
        chk("t4_ack_width", {15'b0, wb_ack_o}, 16'd0);
        rd_chk("t4_set_wins", 1'b1, 16'h0001);
        wr(1'b1, 16'h0001);
        rd_chk("t4_w1c", 1'b1, 16'h0000);
        pulse(3'b010);
        rsel = 16'h0000;
        push(16'h0000, 3'b000);
        fetch(1'b1);
        rd_chk("t5_pend_kept", 1'b1, 16'h0002);
        rsel = 16'hA5A5;
        push(16'hA5A5, 3'b000);
        fetch(1'b1);
        push(VEC[1], 3'b010);
        fetch(1'b0);
        rsel = 16'h1234;
        push(16'h1234, 3'b000);
        fetch(1'b0);
        imode = 3'b110;
        @(negedge clk); ireq = 3'b001;
        repeat (2) @(negedge clk);
        chk("lvl_irq", {15'b0, wb_irq_o}, 16'd1);
        wr(1'b1, 16'h0001);
        rd_chk("lvl_pend_nowc", 1'b1, 16'h0001);
        push(VEC[0], 3'b001);
        fetch(1'b0);
        chk("lvl_rereq", {15'b0, wb_irq_o}, 16'd1);
        ireq = '0;
        @(negedge clk);
        chk("lvl_drop", {15'b0, wb_irq_o}, 16'd0);
        imode = 3'b111;
        wr(1'b0, 16'h0003);
        pulse(3'b011);
        @(negedge clk); vic_stb_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!vic_ack_o && n < 10);
        chk("t6_ack", {15'b0, vic_ack_o}, 16'd1);
        chk("t6_vec", vic_dat_o, VEC[1]);
        chk("t6_iack", {13'b0, iack}, 16'h0002);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_ack_rst", {15'b0, vic_ack_o}, 16'd0);
        chk("t6_iack_rst", {13'b0, iack}, 16'd0);
        chk("t6_irq_rst", {15'b0, wb_irq_o}, 16'd0);
        chk("t6_dat_rst", vic_dat_o, 16'd0);
        rst = 1'b0; vic_stb_i = 1'b0;
        rd_chk("t6_mask", 1'b0, 16'h0007);
        rd_chk("t6_pend", 1'b1, 16'h0000);
        chk("sb_left", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
